// File: rtl/mux_summer_pkg.sv
// Shared widths for the mux/summer leaf utility.
package mux_summer_pkg;

    localparam int unsigned MUX_WIDTH     = 8;
    localparam int unsigned SEL_WIDTH     = 3;
    localparam int unsigned OPERAND_WIDTH = 3;
    localparam int unsigned SUM_WIDTH     = OPERAND_WIDTH + 1;

endpackage : mux_summer_pkg

// File: rtl/mux_8_1.sv
// 8:1 single-bit selector, purely combinational.
//   mux_in  : data bits 0..7
//   mux_sel : bit index
//   mux_out : mux_in[mux_sel]
module mux_8_1
    import mux_summer_pkg::*;
(
    input  logic [MUX_WIDTH-1:0] mux_in,
    input  logic [SEL_WIDTH-1:0] mux_sel,
    output logic                 mux_out
);

    always_comb begin
        mux_out = mux_in[mux_sel];
    end

endmodule : mux_8_1

// File: rtl/summer_with_one_input.sv
// Accumulating adder: control=0 saves a, control=1 registers a + saved operand.
//   clk, rst : clock and synchronous active-high reset
//   control  : 0 = save operand, 1 = compute sum
//   a        : unsigned operand
//   c        : registered sum
//   c_valid  : one-cycle pulse after each compute edge
module summer_with_one_input
    import mux_summer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     control,
    input  logic [OPERAND_WIDTH-1:0] a,
    output logic [SUM_WIDTH-1:0]     c,
    output logic                     c_valid
);

    logic [OPERAND_WIDTH-1:0] stored_q, stored_d;
    logic [SUM_WIDTH-1:0]     c_q, c_d;
    logic                     c_valid_q, c_valid_d;

    // Next-state: save holds c, compute holds the stored operand.
    always_comb begin
        stored_d  = stored_q;
        c_d       = c_q;
        c_valid_d = 1'b0;
        if (control) begin
            // One extra bit of headroom: 7+7 fits without wrap.
            c_d       = SUM_WIDTH'(a) + SUM_WIDTH'(stored_q);
            c_valid_d = 1'b1;
        end else begin
            stored_d = a;
        end
    end

    // State registers; reset beats any save/compute on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stored_q  <= '0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
        end else begin
            stored_q  <= stored_d;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
        end
    end

    assign c       = c_q;
    assign c_valid = c_valid_q;

endmodule : summer_with_one_input

// File: rtl/mux_summer_unit.sv
// Leaf datapath utility: combinational 8:1 bit mux beside a clocked one-input summer.
//   clk, rst         : clock and synchronous active-high reset (summer only)
//   mux_in, mux_sel  : mux data and select
//   mux_out          : mux_in[mux_sel], combinational
//   control, a       : summer save/compute control and operand
//   c, c_valid       : registered sum and its one-cycle valid pulse
module mux_summer_unit
    import mux_summer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MUX_WIDTH-1:0]     mux_in,
    input  logic [SEL_WIDTH-1:0]     mux_sel,
    output logic                     mux_out,
    input  logic                     control,
    input  logic [OPERAND_WIDTH-1:0] a,
    output logic [SUM_WIDTH-1:0]     c,
    output logic                     c_valid
);

    mux_8_1 u_mux (
        .mux_in  (mux_in),
        .mux_sel (mux_sel),
        .mux_out (mux_out)
    );

    summer_with_one_input u_summer (
        .clk     (clk),
        .rst     (rst),
        .control (control),
        .a       (a),
        .c       (c),
        .c_valid (c_valid)
    );

endmodule : mux_summer_unit

// File: tb/tb_mux_summer_unit.sv
// Self-checking bench for mux_summer_unit: per-cycle model compare plus directed literals.
module tb_mux_summer_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mux_in;
    logic [2:0] mux_sel;
    logic       mux_out;
    logic       control;
    logic [2:0] a;
    logic [3:0] c;
    logic       c_valid;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    int m_stored = 0;
    int m_c      = 0;
    int m_valid  = 0;

    int exp_sweep_mux[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int exp_seq[8]       = '{0, 1, 3, 5, 7, 9, 11, 13};

    always #5 clk = ~clk;

    mux_summer_unit dut (
        .clk     (clk),
        .rst     (rst),
        .mux_in  (mux_in),
        .mux_sel (mux_sel),
        .mux_out (mux_out),
        .control (control),
        .a       (a),
        .c       (c),
        .c_valid (c_valid)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the summer rules, evaluated on the inputs present at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_stored = 0;
            m_c      = 0;
            m_valid  = 0;
        end else if (control == 1'b0) begin
            m_stored = int'(a);
            m_valid  = 0;
        end else begin
            m_c     = m_stored + int'(a);
            m_valid = 1;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_c", int'(c), m_c);
            chk("model_c_valid", int'(c_valid), m_valid);
            chk("model_mux_out", int'(mux_out), int'((mux_in >> mux_sel) & 8'd1));
        end
    end

    task automatic step(input logic r, input logic ctl, input logic [2:0] av);
        rst     = r;
        control = ctl;
        a       = av;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; control = 1'b0; a = 3'd0; mux_in = 8'h00; mux_sel = 3'd0;
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0);
        check_en = 1'b1;
        chk("reset_c", int'(c), 0);
        chk("reset_c_valid", int'(c_valid), 0);

        // Mux sweep over 1100_1100
        mux_in = 8'b1100_1100;
        for (int s = 0; s < 8; s++) begin
            mux_sel = 3'(s);
            #1;
            chk("mux_sweep", int'(mux_out), exp_sweep_mux[s]);
        end

        // One-hot positions
        for (int p = 0; p < 8; p++) begin
            mux_in = 8'(1 << p);
            for (int s = 0; s < 8; s++) begin
                mux_sel = 3'(s);
                #1;
                chk("mux_onehot", int'(mux_out), (p == s) ? 1 : 0);
            end
        end
        mux_in = 8'b1010_0110;

        // Save 3, compute 5
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd3);
        step(1'b0, 1'b1, 3'd5);
        chk("save_compute_c", int'(c), 8);
        chk("save_compute_valid", int'(c_valid), 1);
        step(1'b0, 1'b0, 3'd1);
        chk("after_save_c", int'(c), 8);
        chk("after_save_valid", int'(c_valid), 0);

        // Repeated compute reuses stored=1
        step(1'b0, 1'b1, 3'd2);
        chk("repeat_compute1", int'(c), 3);
        step(1'b0, 1'b1, 3'd6);
        chk("repeat_compute2", int'(c), 7);
        chk("repeat_compute2_valid", int'(c_valid), 1);

        // Boundary 7+7
        step(1'b0, 1'b0, 3'd7);
        step(1'b0, 1'b1, 3'd7);
        chk("max_sum", int'(c), 14);

        // Compute directly after reset
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd6);
        chk("compute_after_reset", int'(c), 6);

        // Sequential sweep
        step(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'((i == 0) ? 0 : i - 1));
            step(1'b0, 1'b1, 3'(i));
            chk("seq_sweep", int'(c), exp_seq[i]);
        end

        // Reset priority over compute
        step(1'b0, 1'b0, 3'd5);
        step(1'b1, 1'b1, 3'd7);
        chk("rst_prio_c", int'(c), 0);
        chk("rst_prio_valid", int'(c_valid), 0);
        step(1'b0, 1'b1, 3'd2);
        chk("post_rst_compute", int'(c), 2);
        chk("post_rst_valid", int'(c_valid), 1);

        step(1'b0, 1'b0, 3'd0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux_summer_unit
